// File: rtl/regfile_sb_if.sv
// Bus bundle between the PE pipeline and the scoreboarded register file.
// Parameters: DATA_W (data width), ADDR_W (address width).
// Signals:
//   write port      wr_en, wr_addr, wr_data
//   scoreboard set  sb_set, sb_addr
//   read request    rd_req, rd_both, rd_addr_a, rd_addr_b
//   read response   rd_data_a, rd_data_b, rd_valid, rd_busy
//   status          sb_busy (one bit per register)
// Modports: master (pipeline side), slave (register file side).
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic              rd_req;
    logic              rd_both;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_valid;
    logic              rd_busy;
    logic [DEPTH-1:0]  sb_busy;

    modport master (
        output wr_en, wr_addr, wr_data, sb_set, sb_addr,
               rd_req, rd_both, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, rd_valid, rd_busy, sb_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, sb_set, sb_addr,
               rd_req, rd_both, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, rd_valid, rd_busy, sb_busy
    );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with a per-register pending-write scoreboard
// and a stalling request/valid read port (IDLE/WAIT FSM).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    regfile_sb_if.slave: write port, scoreboard set, read request,
//          registered read response and the sb_busy vector
// Optional feature: define REGFILE_BYPASS_EN to forward same-edge write data
// into reads (and release a stalled read on its clearing writeback edge).
module regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    regfile_sb_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr_a;
        logic [ADDR_W-1:0] addr_b;
        logic              both;
    } req_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  sb_q, sb_d;
    logic [0:0]        state_q, state_d;
    req_t              req_q, req_d, req_c;
    logic [DATA_W-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    logic              valid_q, valid_d, busy_q, busy_d;
    logic              wr_ok_c, hit_a_c, hit_b_c, stall_c, active_c;

    // Writes to the hardwired-zero register are dropped
    always_comb begin
        wr_ok_c = bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));
    end

    // Scoreboard next state: writeback clears, issue sets (set wins on collision)
    always_comb begin
        sb_d = sb_q;
        if (bus.wr_en) sb_d[bus.wr_addr] = 1'b0;
        if (bus.sb_set) sb_d[bus.sb_addr] = 1'b1;
        if (ZERO_REG) sb_d[0] = 1'b0;
    end

    // Register array
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok_c) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sb_q <= '0;
        else        sb_q <= sb_d;
    end

    // Read FSM next state and registered read outputs
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        valid_d  = 1'b0;
        busy_d   = 1'b0;

        // In WAIT the latched request is re-evaluated; new requests are ignored
        if (state_q == WAIT) begin
            req_c = req_q;
        end else begin
            req_c.addr_a = bus.rd_addr_a;
            req_c.addr_b = bus.rd_addr_b;
            req_c.both   = bus.rd_both;
        end
        active_c = (state_q == WAIT) || bus.rd_req;

`ifdef REGFILE_BYPASS_EN
        hit_a_c = bus.wr_en && (bus.wr_addr == req_c.addr_a) && (req_c.addr_a != '0);
        hit_b_c = bus.wr_en && (bus.wr_addr == req_c.addr_b) && (req_c.addr_b != '0);
`else
        hit_a_c = 1'b0;
        hit_b_c = 1'b0;
`endif

        // A forwarded writeback satisfies its own pending scoreboard entry
        stall_c = (sb_q[req_c.addr_a] && !hit_a_c) ||
                  (req_c.both && sb_q[req_c.addr_b] && !hit_b_c);

        if (active_c) begin
            if (stall_c) begin
                state_d = WAIT;
                req_d   = req_c;
                busy_d  = 1'b1;
            end else begin
                state_d = IDLE;
                valid_d = 1'b1;
                if (ZERO_REG && (req_c.addr_a == '0)) data_a_d = '0;
                else if (hit_a_c)                     data_a_d = bus.wr_data;
                else                                  data_a_d = mem[req_c.addr_a];
                if (!req_c.both)                            data_b_d = '0;
                else if (ZERO_REG && (req_c.addr_b == '0)) data_b_d = '0;
                else if (hit_b_c)                           data_b_d = bus.wr_data;
                else                                        data_b_d = mem[req_c.addr_b];
            end
        end
    end

    // FSM state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            req_q    <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.rd_data_a = data_a_q;
    assign bus.rd_data_b = data_b_q;
    assign bus.rd_valid  = valid_q;
    assign bus.rd_busy   = busy_q;
    assign bus.sb_busy   = sb_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default 32x32, ZERO_REG=1).
// Honors REGFILE_BYPASS_EN for the expected release latency and same-edge read data.
module tb_regfile_sb;
    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.sb_set = 1'b0; bus.sb_addr = '0;
        bus.rd_req = 1'b0; bus.rd_both = 1'b0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    endtask

    task automatic test_reset();
        n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.rd_valid); else n_pass++;
        n_total++; if (bus.rd_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.rd_busy); else n_pass++;
        n_total++; if (bus.rd_data_a !== 32'h0) $display("FAIL reset_data_a got=%h exp=0", bus.rd_data_a); else n_pass++;
        n_total++; if (bus.rd_data_b !== 32'h0) $display("FAIL reset_data_b got=%h exp=0", bus.rd_data_b); else n_pass++;
        n_total++; if (bus.sb_busy !== 32'h0) $display("FAIL reset_sb got=%h exp=0", bus.sb_busy); else n_pass++;
    endtask

    task automatic test_write_read();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
        step();
        bus.wr_addr = 5'd6; bus.wr_data = 32'h0BADF00D;
        bus.rd_req = 1'b1; bus.rd_both = 1'b1; bus.rd_addr_a = 5'd5; bus.rd_addr_b = 5'd0;
        step();
        bus.wr_en = 1'b0; bus.rd_req = 1'b0;
        n_total++; if (bus.rd_valid !== 1'b1) $display("FAIL wr_rd_valid got=%b exp=1", bus.rd_valid); else n_pass++;
        n_total++; if (bus.rd_data_a !== 32'hDEADBEEF) $display("FAIL wr_rd_a got=%h exp=deadbeef", bus.rd_data_a); else n_pass++;
        n_total++; if (bus.rd_data_b !== 32'h0) $display("FAIL wr_rd_b0 got=%h exp=0", bus.rd_data_b); else n_pass++;
        step();
        n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL wr_rd_pulse got=%b exp=0", bus.rd_valid); else n_pass++;
        n_total++; if (bus.rd_data_a !== 32'hDEADBEEF) $display("FAIL wr_rd_hold got=%h exp=deadbeef", bus.rd_data_a); else n_pass++;
        bus.rd_req = 1'b1; bus.rd_both = 1'b1; bus.rd_addr_a = 5'd6; bus.rd_addr_b = 5'd5;
        step();
        bus.rd_req = 1'b0;
        n_total++; if (bus.rd_data_a !== 32'h0BADF00D) $display("FAIL rd_two_a got=%h exp=0badf00d", bus.rd_data_a); else n_pass++;
        n_total++; if (bus.rd_data_b !== 32'hDEADBEEF) $display("FAIL rd_two_b got=%h exp=deadbeef", bus.rd_data_b); else n_pass++;
    endtask

    task automatic test_zero_reg();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h1234;
        step();
        bus.wr_en = 1'b0;
        bus.rd_req = 1'b1; bus.rd_both = 1'b0; bus.rd_addr_a = 5'd0;
        step();
        bus.rd_req = 1'b0;
        n_total++; if (bus.rd_valid !== 1'b1) $display("FAIL x0_valid got=%b exp=1", bus.rd_valid); else n_pass++;
        n_total++; if (bus.rd_data_a !== 32'h0) $display("FAIL x0_data got=%h exp=0", bus.rd_data_a); else n_pass++;
        bus.sb_set = 1'b1; bus.sb_addr = 5'd0;
        step();
        bus.sb_set = 1'b0;
        n_total++; if (bus.sb_busy !== 32'h0) $display("FAIL x0_sb got=%h exp=0", bus.sb_busy); else n_pass++;
    endtask

    task automatic test_stall();
        bus.sb_set = 1'b1; bus.sb_addr = 5'd7;
        step();
        bus.sb_set = 1'b0;
        n_total++; if (bus.sb_busy !== 32'h80) $display("FAIL stall_sb got=%h exp=80", bus.sb_busy); else n_pass++;
        bus.rd_req = 1'b1; bus.rd_both = 1'b0; bus.rd_addr_a = 5'd7;
        step();
        n_total++; if (bus.rd_busy !== 1'b1) $display("FAIL stall_busy got=%b exp=1", bus.rd_busy); else n_pass++;
        n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL stall_novalid got=%b exp=0", bus.rd_valid); else n_pass++;
        // A request presented during WAIT must be ignored
        bus.rd_addr_a = 5'd5;
        step();
        bus.rd_req = 1'b0;
        n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL wait_ignore got=%b exp=0", bus.rd_valid); else n_pass++;
        step();
        n_total++; if (bus.rd_busy !== 1'b1) $display("FAIL wait_busy got=%b exp=1", bus.rd_busy); else n_pass++;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h55;
        step();
        bus.wr_en = 1'b0;
`ifndef REGFILE_BYPASS_EN
        n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL nobyp_early got=%b exp=0", bus.rd_valid); else n_pass++;
        step();
`endif
        n_total++; if (bus.rd_valid !== 1'b1) $display("FAIL release_valid got=%b exp=1", bus.rd_valid); else n_pass++;
        n_total++; if (bus.rd_data_a !== 32'h55) $display("FAIL release_data got=%h exp=55", bus.rd_data_a); else n_pass++;
        n_total++; if (bus.rd_busy !== 1'b0) $display("FAIL release_busy got=%b exp=0", bus.rd_busy); else n_pass++;
        step();
        n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL release_pulse got=%b exp=0", bus.rd_valid); else n_pass++;
    endtask

    task automatic test_rd_both0();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h33;
        bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
        step();
        bus.wr_en = 1'b0; bus.sb_set = 1'b0;
        bus.rd_req = 1'b1; bus.rd_both = 1'b0; bus.rd_addr_a = 5'd3; bus.rd_addr_b = 5'd9;
        step();
        bus.rd_req = 1'b0;
        n_total++; if (bus.rd_valid !== 1'b1) $display("FAIL both0_valid got=%b exp=1", bus.rd_valid); else n_pass++;
        n_total++; if (bus.rd_busy !== 1'b0) $display("FAIL both0_busy got=%b exp=0", bus.rd_busy); else n_pass++;
        n_total++; if (bus.rd_data_a !== 32'h33) $display("FAIL both0_a got=%h exp=33", bus.rd_data_a); else n_pass++;
        n_total++; if (bus.rd_data_b !== 32'h0) $display("FAIL both0_b got=%h exp=0", bus.rd_data_b); else n_pass++;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h99;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic test_set_wins();
        bus.sb_set = 1'b1; bus.sb_addr = 5'd4;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'hAA;
        step();
        bus.sb_set = 1'b0;
        n_total++; if (bus.sb_busy !== 32'h10) $display("FAIL set_wins got=%h exp=10", bus.sb_busy); else n_pass++;
        step();
        bus.wr_en = 1'b0;
        n_total++; if (bus.sb_busy !== 32'h0) $display("FAIL wr_clears got=%h exp=0", bus.sb_busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'hA0A00000; vals[1] = 32'hA0A00001; vals[2] = 32'hA0A00002; vals[3] = 32'hA0A00003;
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 5'(10 + i); bus.wr_data = vals[i];
            step();
        end
        bus.wr_en = 1'b0;
        bus.rd_both = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.rd_req = 1'b1; bus.rd_addr_a = 5'(10 + i);
            step();
            n_total++; if (bus.rd_valid !== 1'b1) $display("FAIL b2b_valid%0d got=%b exp=1", i, bus.rd_valid); else n_pass++;
            n_total++; if (bus.rd_data_a !== vals[i]) $display("FAIL b2b_data%0d got=%h exp=%h", i, bus.rd_data_a, vals[i]); else n_pass++;
        end
        bus.rd_req = 1'b0;
        step();
        n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL b2b_end got=%b exp=0", bus.rd_valid); else n_pass++;
    endtask

    task automatic test_same_edge();
        logic [31:0] exp_v;
`ifdef REGFILE_BYPASS_EN
        exp_v = 32'hCAFEF00D;
`else
        exp_v = 32'hA0A00000;
`endif
        bus.wr_en = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = 32'hCAFEF00D;
        bus.rd_req = 1'b1; bus.rd_both = 1'b0; bus.rd_addr_a = 5'd10;
        step();
        bus.wr_en = 1'b0;
        n_total++; if (bus.rd_data_a !== exp_v) $display("FAIL same_edge got=%h exp=%h", bus.rd_data_a, exp_v); else n_pass++;
        step();
        bus.rd_req = 1'b0;
        n_total++; if (bus.rd_data_a !== 32'hCAFEF00D) $display("FAIL after_write got=%h exp=cafef00d", bus.rd_data_a); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        bus.sb_set = 1'b1; bus.sb_addr = 5'd8;
        step();
        bus.sb_set = 1'b0;
        bus.rd_req = 1'b1; bus.rd_both = 1'b0; bus.rd_addr_a = 5'd8;
        step();
        bus.rd_req = 1'b0;
        n_total++; if (bus.rd_busy !== 1'b1) $display("FAIL rw_enter got=%b exp=1", bus.rd_busy); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (bus.rd_busy !== 1'b0) $display("FAIL rw_busy got=%b exp=0", bus.rd_busy); else n_pass++;
        n_total++; if (bus.sb_busy !== 32'h0) $display("FAIL rw_sb got=%h exp=0", bus.sb_busy); else n_pass++;
        n_total++; if (bus.rd_data_a !== 32'h0) $display("FAIL rw_data got=%h exp=0", bus.rd_data_a); else n_pass++;
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL rw_novalid%0d got=%b exp=0", i, bus.rd_valid); else n_pass++;
        end
        bus.rd_req = 1'b1; bus.rd_both = 1'b1; bus.rd_addr_a = 5'd5; bus.rd_addr_b = 5'd10;
        step();
        bus.rd_req = 1'b0;
        n_total++; if (bus.rd_valid !== 1'b1) $display("FAIL rw_rd_valid got=%b exp=1", bus.rd_valid); else n_pass++;
        n_total++; if (bus.rd_data_a !== 32'h0) $display("FAIL rw_x5 got=%h exp=0", bus.rd_data_a); else n_pass++;
        n_total++; if (bus.rd_data_b !== 32'h0) $display("FAIL rw_x10 got=%h exp=0", bus.rd_data_b); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        idle_inputs();
        step();
        step();
        test_reset();
        reset = 1'b1;
        step();
        test_write_read();
        test_zero_reg();
        test_stall();
        test_rd_both0();
        test_set_wins();
        test_back_to_back();
        test_same_edge();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 32x32 register system for the RISC-V PE.
- Adds configurable width and depth, a hardwired-zero register, and a per-register pending-write scoreboard.
- Reads use a request/valid handshake and stall while a source register has an outstanding producer.
- Sits between decode/issue (scoreboard set, read request) and writeback (write port) of the PE pipeline.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes, and is never busy.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe (writeback).
- wr_addr  in  ADDR_W  destination register.
- wr_data  in  DATA_W  write data.
- sb_set  in  1  mark sb_addr busy (instruction issued with that destination).
- sb_addr  in  ADDR_W  register to mark busy.
- rd_req  in  1  read request, sampled only when rd_busy=0.
- rd_both  in  1  0: read port A only; 1: read A and B.
- rd_addr_a  in  ADDR_W  source register A.
- rd_addr_b  in  ADDR_W  source register B.
- rd_data_a  out  DATA_W  registered read data A.
- rd_data_b  out  DATA_W  registered read data B (0 when rd_both=0).
- rd_valid  out  1  one-cycle pulse; rd_data_a/b valid.
- rd_busy  out  1  request held, waiting on the scoreboard.
- sb_busy  out  DEPTH  scoreboard bit vector.

Behaviour:
- Reset (reset=0, async):
  - all registers 0, sb_busy 0.
  - rd_data_a/b 0, rd_valid 0, rd_busy 0, FSM to IDLE.
  - Reset asserted mid-WAIT: the pending request is dropped and no rd_valid is produced.
- Write:
  - At the rising edge with wr_en=1, mem[wr_addr] <= wr_data and sb_busy[wr_addr] clears.
  - With ZERO_REG=1, writes to address 0 are discarded.
- Scoreboard:
  - sb_set sets sb_busy[sb_addr] (ignored for address 0 when ZERO_REG=1).
  - sb_set and a write to the same address in the same edge: the set wins and the bit stays 1.
- Read FSM, states IDLE and WAIT:
  - IDLE with rd_req=1: latch the addresses and rd_both into a request register.
  - A needed source is busy when sb_busy is set for it; port B is needed only if rd_both=1.
  - No needed source busy: at that edge, load rd_data from the array and pulse rd_valid=1 for the next cycle. Latency is 1 cycle. Stay IDLE.
  - Any needed source busy: go to WAIT; rd_busy=1 from the next cycle. rd_req is ignored while in WAIT.
  - WAIT: re-evaluate the latched request every cycle against the current sb_busy. When no needed source is busy, load data, pulse rd_valid, and return to IDLE.
- Back-to-back requests: rd_req is accepted in the same cycle rd_valid is high, giving 1 result per cycle when nothing is busy.
- Port B output is forced to 0 when rd_both=0.
- An address-0 read returns 0 when ZERO_REG=1.
- Same-edge write and read of the same address (not busy): behaviour is set by the optional feature below.
- rd_valid is high for exactly one cycle per accepted request; rd_data holds its value until the next load.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding; for each needed source whose address matches wr_addr with wr_en=1 (address 0 excluded), data is taken from wr_data.
  - In WAIT, the busy-clearing write counts as not busy in that same cycle. rd_valid then follows the writeback edge by one cycle.
- Undefined:
  - Reads return the array contents before the edge.
  - In WAIT, release happens only after sb_busy is actually clear, one cycle later than with bypass.
  - A same-edge write/read in IDLE returns the old value.

Test Plan:
- Write x5=0xDEADBEEF; next cycle rd_req, rd_both=1, a=5, b=0 -> one cycle later rd_valid=1, rd_data_a=0xDEADBEEF, rd_data_b=0.
- wr_en to x0 with 0x1234, then read x0 -> rd_data_a=0; sb_set on x0 -> sb_busy[0] stays 0.
- sb_set x7; rd_req a=7 -> rd_busy=1 and no rd_valid. Write x7=0x55 three cycles later -> rd_valid with 0x55: 1 cycle after the write with REGFILE_BYPASS_EN, 2 cycles without.
- sb_set x9; rd_req a=3, b=9, rd_both=0 -> no stall, rd_valid after 1 cycle, rd_data_b=0.
- In the same edge: sb_set x4 and wr_en x4 -> sb_busy[4]=1 after the edge. Drive rd_req every cycle for 4 independent non-busy reads -> 4 consecutive rd_valid pulses.
- Enter WAIT on x8, then assert reset=0 -> rd_busy=0, rd_valid never pulses, all registers read 0 after release.
